// File: rtl/dice_race_pkg.sv
// Shared types and constants for the dice race game controller.
package dice_race_pkg;

    localparam int MAX_PLAYERS = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_ROLL = 3'd1,
        MOVE      = 3'd2,
        CHECK     = 3'd3,
        NEXT      = 3'd4,
        WIN       = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        COLOR_NONE  = 2'd0,
        COLOR_RED   = 2'd1,
        COLOR_GREEN = 2'd2,
        COLOR_BLUE  = 2'd3
    } color_t;

    function automatic logic [1:0] next_player(input logic [1:0] cur, input int num_players);
        return (int'(cur) == num_players - 1) ? 2'd0 : cur + 2'd1;
    endfunction

endpackage

// File: rtl/dice_race_step_timer.sv
// Free-running animation timer: one-cycle tick every STEP_TICKS enabled cycles.
module step_timer #(
    parameter int STEP_TICKS = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_TICKS - 1);

    logic [CNT_W-1:0] count_reg;

    assign tick = en && !clear && (count_reg == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= tick ? '0 : count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/dice_race_controller.sv
// Turn-based board race driven by the stabilised die result.
// Optional DICE_RACE_EXACT_FINISH_EN: overshooting rolls pass the turn without moving.
module dice_race_controller
    import dice_race_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int BOARD_LEN   = 30,
    parameter int STEP_TICKS  = 12_500_000,
    parameter int POS_W       = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         result_ready,
    input  logic [1:0]                   stable_color,
    input  logic [1:0]                   movement_steps,
    output logic [NUM_PLAYERS*POS_W-1:0] positions,
    output logic [1:0]                   cur_player,
    output logic                         moving,
    output logic                         step_pulse,
    output logic [1:0]                   last_roll,
    output logic                         game_over,
    output logic [1:0]                   winner
);

    state_t           state_reg;
    logic [POS_W-1:0] pos_reg [MAX_PLAYERS];
    logic [1:0]       cur_player_reg;
    logic [1:0]       remaining_reg;
    logic [1:0]       last_roll_reg;
    logic [1:0]       winner_reg;
    logic             armed_reg;
    logic             moving_reg;
    logic             step_pulse_reg;
    logic             game_over_reg;

    logic             tick;
    logic             timer_clear;
    logic             roll_ok;
    logic [POS_W-1:0] cur_pos;

    assign cur_pos     = pos_reg[cur_player_reg];
    assign timer_clear = start || (state_reg != MOVE);
    assign roll_ok     = (state_reg == WAIT_ROLL) && result_ready && armed_reg &&
                         (color_t'(stable_color) != COLOR_NONE) && (movement_steps != 2'd0);

`ifdef DICE_RACE_EXACT_FINISH_EN
    logic [POS_W+1:0] roll_target;
    logic             overshoot;
    assign roll_target = (POS_W+2)'(cur_pos) + (POS_W+2)'(movement_steps);
    assign overshoot   = roll_target > (POS_W+2)'(BOARD_LEN);
`endif

    step_timer #(
        .STEP_TICKS(STEP_TICKS)
    ) u_step_timer (
        .clk  (clk),
        .reset(reset),
        .en   (state_reg == MOVE),
        .clear(timer_clear),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            for (int i = 0; i < MAX_PLAYERS; i++) pos_reg[i] <= '0;
            cur_player_reg <= 2'd0;
            remaining_reg  <= 2'd0;
            last_roll_reg  <= 2'd0;
            winner_reg     <= 2'd0;
            armed_reg      <= 1'b1;
            moving_reg     <= 1'b0;
            step_pulse_reg <= 1'b0;
            game_over_reg  <= 1'b0;
        end else begin
            step_pulse_reg <= 1'b0;
            // An empty ROI re-arms; a later accept in this cycle overrides it.
            if (color_t'(stable_color) == COLOR_NONE) armed_reg <= 1'b1;

            if (start) begin
                for (int i = 0; i < MAX_PLAYERS; i++) pos_reg[i] <= '0;
                cur_player_reg <= 2'd0;
                remaining_reg  <= 2'd0;
                armed_reg      <= 1'b1;
                moving_reg     <= 1'b0;
                game_over_reg  <= 1'b0;
                state_reg      <= WAIT_ROLL;
            end else begin
                case (state_reg)
                    IDLE: ;
                    WAIT_ROLL: begin
                        if (roll_ok) begin
                            armed_reg     <= 1'b0;
                            last_roll_reg <= movement_steps;
`ifdef DICE_RACE_EXACT_FINISH_EN
                            if (overshoot) begin
                                state_reg <= NEXT;
                            end else begin
                                remaining_reg <= movement_steps;
                                moving_reg    <= 1'b1;
                                state_reg     <= MOVE;
                            end
`else
                            remaining_reg <= movement_steps;
                            moving_reg    <= 1'b1;
                            state_reg     <= MOVE;
`endif
                        end
                    end
                    MOVE: begin
                        if (remaining_reg == 2'd0) begin
                            moving_reg <= 1'b0;
                            state_reg  <= CHECK;
                        end else if (tick) begin
                            if (cur_pos != POS_W'(BOARD_LEN)) begin
                                pos_reg[cur_player_reg] <= cur_pos + 1'b1;
                                step_pulse_reg          <= 1'b1;
                            end
                            // Reaching the finish square ends the roll early.
                            remaining_reg <= (cur_pos >= POS_W'(BOARD_LEN - 1)) ? 2'd0
                                                                                 : remaining_reg - 2'd1;
                        end
                    end
                    CHECK: begin
                        if (cur_pos == POS_W'(BOARD_LEN)) begin
                            winner_reg    <= cur_player_reg;
                            game_over_reg <= 1'b1;
                            state_reg     <= WIN;
                        end else begin
                            state_reg <= NEXT;
                        end
                    end
                    NEXT: begin
                        cur_player_reg <= next_player(cur_player_reg, NUM_PLAYERS);
                        state_reg      <= WAIT_ROLL;
                    end
                    WIN: ;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_pack
        assign positions[gi*POS_W +: POS_W] = pos_reg[gi];
    end

    assign cur_player = cur_player_reg;
    assign moving     = moving_reg;
    assign step_pulse = step_pulse_reg;
    assign last_roll  = last_roll_reg;
    assign game_over  = game_over_reg;
    assign winner     = winner_reg;

endmodule
